// File: rtl/dma_ctrl_multi.sv
// dma_ctrl_multi: parametrised multi-channel DMA controller; define DMA_ROTATE_PRIO_EN for rotating priority
module dma_ctrl_multi #(
   parameter int NCH = 4,
   parameter int AW  = 16,
   parameter int CW  = 16,
   parameter int DW  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cs,
   input  logic                   wr,
   input  logic                   rd,
   input  logic [$clog2(NCH)+1:0] addr,
   input  logic [DW-1:0]          din,
   output logic [DW-1:0]          dout,
   input  logic [NCH-1:0]         dreq,
   input  logic                   hlda,
   input  logic                   ready,
   output logic                   hrq,
   output logic [NCH-1:0]         dack,
   output logic                   aen,
   output logic [AW-1:0]          mem_addr,
   output logic                   memr,
   output logic                   memw,
   output logic                   ior,
   output logic                   iow,
   output logic                   eop
);
   localparam int CHW = $clog2(NCH);

   typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, S4} state_t;

   state_t          state_q, state_d;
   logic [CHW-1:0]  ch_q, ch_d, prio_q, prio_d, win;
   logic            found;
   int              idx;
   logic [AW-1:0]   base_addr_q [NCH];
   logic [AW-1:0]   base_addr_d [NCH];
   logic [AW-1:0]   cur_addr_q  [NCH];
   logic [AW-1:0]   cur_addr_d  [NCH];
   logic [CW-1:0]   base_cnt_q  [NCH];
   logic [CW-1:0]   base_cnt_d  [NCH];
   logic [CW-1:0]   cur_cnt_q   [NCH];
   logic [CW-1:0]   cur_cnt_d   [NCH];
   logic [4:0]      mode_q      [NCH];
   logic [4:0]      mode_d      [NCH];
   logic [1:0]      cmd_q, cmd_d;
   logic [NCH-1:0]  mask_q, mask_d, tc_q, tc_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic [CHW-1:0]  a_ch;
   logic [1:0]      a_reg;
   logic            ch_ok, wr_ok, rd_ok, tc_hit, auto_rl, act, rs, ws;
   logic [1:0]      xt;

   assign a_ch   = addr[CHW+1:2];
   assign a_reg  = addr[1:0];
   assign ch_ok  = 32'(a_ch) < NCH;
   assign wr_ok  = cs && wr && state_q == IDLE;
   assign rd_ok  = cs && rd;
   assign tc_hit = state_q == S4 && cur_cnt_q[ch_q] == '0;
   assign auto_rl = tc_hit && mode_q[ch_q][2];

   // Arbiter: first unmasked requester searching upward from the priority pointer
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NCH; i++) begin
         idx = (int'(prio_q) + i) % NCH;
         if (!found && dreq[idx] && !mask_q[idx]) begin
            found = 1'b1;
            win   = CHW'(idx);
         end
      end
   end

   // Next state: register port, FSM sequencing and S4 bookkeeping
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      prio_d      = prio_q;
      cmd_d       = cmd_q;
      mask_d      = mask_q;
      tc_d        = tc_q;
      dout_d      = dout_q;
      base_addr_d = base_addr_q;
      cur_addr_d  = cur_addr_q;
      base_cnt_d  = base_cnt_q;
      cur_cnt_d   = cur_cnt_q;
      mode_d      = mode_q;
      if (rd_ok) begin
         dout_d = (a_reg == 2'd0) ? (ch_ok ? DW'(cur_addr_q[a_ch]) : '0) :
                  (a_reg == 2'd1) ? (ch_ok ? DW'(cur_cnt_q[a_ch]) : '0) :
                  (a_reg == 2'd2) ? (ch_ok ? DW'(mode_q[a_ch]) : '0) :
                  (a_ch == CHW'(0)) ? DW'(cmd_q) :
                  (a_ch == CHW'(1)) ? DW'(mask_q) :
                  (32'(a_ch) == 2) ? DW'({dreq, tc_q}) : '0;
         if (a_reg == 2'd3 && 32'(a_ch) == 2)
            tc_d = '0;
      end
      if (wr_ok && ch_ok && a_reg == 2'd0) begin
         base_addr_d[a_ch] = din[AW-1:0];
         cur_addr_d[a_ch]  = din[AW-1:0];
      end
      if (wr_ok && ch_ok && a_reg == 2'd1) begin
         base_cnt_d[a_ch] = din[CW-1:0];
         cur_cnt_d[a_ch]  = din[CW-1:0];
      end
      if (wr_ok && ch_ok && a_reg == 2'd2)
         mode_d[a_ch] = din[4:0];
      if (wr_ok && a_reg == 2'd3 && a_ch == CHW'(0))
         cmd_d = din[1:0];
      if (wr_ok && a_reg == 2'd3 && a_ch == CHW'(1))
         mask_d = din[NCH-1:0];
      case (state_q)
         IDLE: begin
            if (cmd_q[0] && found) begin
               ch_d    = win;
               state_d = S0;
            end
         end
         S0: state_d = hlda ? S1 : S0;
         S1: state_d = S2;
         S2: state_d = S3;
         S3: state_d = ready ? S4 : S3;
         S4: begin
            cur_addr_d[ch_q] = auto_rl ? base_addr_q[ch_q] :
                               mode_q[ch_q][3] ? cur_addr_q[ch_q] - AW'(1) : cur_addr_q[ch_q] + AW'(1);
            cur_cnt_d[ch_q]  = auto_rl ? base_cnt_q[ch_q] : cur_cnt_q[ch_q] - CW'(1);
            if (tc_hit) begin
               tc_d[ch_q] = 1'b1;
               if (!mode_q[ch_q][2])
                  mask_d[ch_q] = 1'b1;
            end
`ifdef DMA_ROTATE_PRIO_EN
            if (cmd_q[1])
               prio_d = (32'(ch_q) == NCH - 1) ? '0 : ch_q + CHW'(1);
`endif
            state_d = (mode_q[ch_q][4] && !tc_hit) ? S1 : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and register file update with synchronous reset
   always_ff @(posedge clk) begin
      state_q <= reset ? IDLE : state_d;
      ch_q    <= reset ? '0 : ch_d;
      prio_q  <= reset ? '0 : prio_d;
      cmd_q   <= reset ? '0 : cmd_d;
      mask_q  <= reset ? '1 : mask_d;
      tc_q    <= reset ? '0 : tc_d;
      dout_q  <= reset ? '0 : dout_d;
      for (int i = 0; i < NCH; i++) begin
         base_addr_q[i] <= reset ? '0 : base_addr_d[i];
         cur_addr_q[i]  <= reset ? '0 : cur_addr_d[i];
         base_cnt_q[i]  <= reset ? '0 : base_cnt_d[i];
         cur_cnt_q[i]   <= reset ? '0 : cur_cnt_d[i];
         mode_q[i]      <= reset ? '0 : mode_d[i];
      end
   end

   // Bus outputs decoded from the current state and active channel
   always_comb begin
      act      = state_q inside {S1, S2, S3, S4};
      rs       = state_q inside {S2, S3};
      ws       = state_q == S3;
      xt       = mode_q[ch_q][1:0];
      hrq      = state_q != IDLE;
      aen      = act;
      dack     = act ? NCH'(1) << ch_q : '0;
      mem_addr = act ? cur_addr_q[ch_q] : '0;
      ior      = rs && xt == 2'b01;
      memr     = rs && xt == 2'b10;
      memw     = ws && xt == 2'b01;
      iow      = ws && xt == 2'b10;
      eop      = tc_hit;
      dout     = dout_q;
   end
endmodule

// File: tb/tb_dma_ctrl_multi.sv
// tb_dma_ctrl_multi: directed self-checking bench for dma_ctrl_multi
module tb_dma_ctrl_multi;
   logic        clk = 1'b0, reset = 1'b1, cs = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [3:0]  addr = '0;
   logic [15:0] din = '0, dout;
   logic [3:0]  dreq = '0, dack;
   logic        hlda, ready = 1'b1, hrq, aen, memr, memw, ior, iow, eop;
   logic [15:0] mem_addr;
   logic        hlda_en = 1'b0, pulse = 1'b0;
   int          stall_x = 0;
   int          n_cmp = 0, n_bad = 0;
   int          n_xfer, n_eop, eop_at, drops;
   logic [15:0] xa [8];
   logic [3:0]  xs [8], xd [8];
   int          xl [8];
   logic [15:0] v;

   assign hlda = hrq & hlda_en;

   always #5 clk = ~clk;

   dma_ctrl_multi dut (
      .clk(clk), .reset(reset), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .din(din), .dout(dout),
      .dreq(dreq), .hlda(hlda), .ready(ready), .hrq(hrq), .dack(dack), .aen(aen), .mem_addr(mem_addr),
      .memr(memr), .memw(memw), .ior(ior), .iow(iow), .eop(eop)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input int ch, input int r, input logic [15:0] d);
      cs = 1'b1; wr = 1'b1; addr = {2'(ch), 2'(r)}; din = d;
      tick();
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic rd_reg(input int ch, input int r, output logic [15:0] d);
      cs = 1'b1; rd = 1'b1; addr = {2'(ch), 2'(r)};
      tick();
      d = dout;
      cs = 1'b0; rd = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; dreq = '0; hlda_en = 1'b0; pulse = 1'b0; stall_x = 0; ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic prog(input int ch, input logic [15:0] a, input logic [15:0] c, input logic [15:0] m);
      wr_reg(ch, 0, a);
      wr_reg(ch, 1, c);
      wr_reg(ch, 2, m);
   endtask

   task automatic run(input int max, input int stop_x);
      int  len;
      logic pw, ph;
      n_xfer = 0; n_eop = 0; eop_at = 0; drops = 0; len = 0; pw = 1'b0; ph = 1'b0;
      for (int c = 0; c < max; c++) begin
         tick();
         if (ph && !hrq && n_eop == 0) drops++;
         ph = hrq;
         if (memw || iow) begin
            if (!pw && n_xfer < 8) begin
               xa[n_xfer] = mem_addr; xs[n_xfer] = {memr, memw, ior, iow}; xd[n_xfer] = dack;
               n_xfer++; len = 0;
            end
            len++;
            xl[n_xfer-1] = len;
         end
         pw = memw || iow;
         if (eop) begin n_eop++; eop_at = n_xfer; end
         if (pulse && hrq) dreq = '0;
         ready = !((memw || iow) && n_xfer == stall_x && len < 3);
         if (n_eop > 0 || n_xfer >= stop_x) break;
      end
   endtask

   initial begin
      tick();
      tick();
      chk("rst_outs", {hrq, aen, dack, memr, memw, ior, iow, eop}, '0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_dout", 32'(dout), 32'h0);
      reset = 1'b0;
      rd_reg(1, 3, v); chk("rst_mask", 32'(v), 32'hF);
      rd_reg(0, 0, v); chk("rst_cur_addr", 32'(v), 32'h0);

      // single-mode write transfers
      prog(0, 16'h1000, 16'd2, 16'h01);
      wr_reg(1, 3, 16'hE);
      wr_reg(0, 3, 16'h1);
      hlda_en = 1'b1; dreq = 4'b0001;
      run(60, 99);
      dreq = '0;
      chk("t1_nxfer", n_xfer, 3);
      chk("t1_a0", 32'(xa[0]), 32'h1000);
      chk("t1_a1", 32'(xa[1]), 32'h1001);
      chk("t1_a2", 32'(xa[2]), 32'h1002);
      chk("t1_strb0", 32'(xs[0]), 32'b0110);
      chk("t1_strb2", 32'(xs[2]), 32'b0110);
      chk("t1_eop", n_eop, 1);
      chk("t1_eop_at", eop_at, 3);
      repeat (3) tick();
      chk("t1_idle", {hrq, aen}, 2'b00);
      rd_reg(2, 3, v); chk("t1_stat1", 32'(v), 32'h01);
      rd_reg(2, 3, v); chk("t1_stat2", 32'(v), 32'h00);
      rd_reg(1, 3, v); chk("t1_mask", 32'(v), 32'hF);
      rd_reg(0, 0, v); chk("t1_addr", 32'(v), 32'h1003);
      rd_reg(0, 1, v); chk("t1_cnt", 32'(v), 32'hFFFF);

      // autoinit reload
      do_reset();
      prog(0, 16'h1000, 16'd2, 16'h05);
      wr_reg(1, 3, 16'hE);
      wr_reg(0, 3, 16'h1);
      hlda_en = 1'b1; dreq = 4'b0001;
      run(60, 99);
      dreq = '0;
      repeat (3) tick();
      chk("t2_eop", n_eop, 1);
      rd_reg(0, 0, v); chk("t2_addr", 32'(v), 32'h1000);
      rd_reg(0, 1, v); chk("t2_cnt", 32'(v), 32'h2);
      rd_reg(1, 3, v); chk("t2_mask", 32'(v), 32'hE);

      // decrement read with wrap
      do_reset();
      prog(0, 16'h0000, 16'd0, 16'h0A);
      wr_reg(1, 3, 16'hE);
      wr_reg(0, 3, 16'h1);
      hlda_en = 1'b1; dreq = 4'b0001;
      run(30, 99);
      dreq = '0;
      repeat (2) tick();
      chk("t3_nxfer", n_xfer, 1);
      chk("t3_xaddr", 32'(xa[0]), 32'h0000);
      chk("t3_strb", 32'(xs[0]), 32'b1001);
      chk("t3_eop", n_eop, 1);
      rd_reg(0, 0, v); chk("t3_wrap", 32'(v), 32'hFFFF);

      // block mode with wait states, dreq dropped after grant
      do_reset();
      prog(0, 16'h2000, 16'd3, 16'h11);
      wr_reg(1, 3, 16'hE);
      wr_reg(0, 3, 16'h1);
      hlda_en = 1'b1; dreq = 4'b0001; pulse = 1'b1; stall_x = 2;
      run(60, 99);
      pulse = 1'b0; stall_x = 0; ready = 1'b1;
      chk("t4_nxfer", n_xfer, 4);
      chk("t4_s3len1", xl[0], 1);
      chk("t4_s3len2", xl[1], 3);
      chk("t4_s3len4", xl[3], 1);
      chk("t4_a3", 32'(xa[3]), 32'h2003);
      chk("t4_hrq_drops", drops, 0);
      chk("t4_eop_at", eop_at, 4);

      // priority between channels 1 and 2
      do_reset();
      prog(1, 16'h0100, 16'd5, 16'h01);
      prog(2, 16'h0200, 16'd5, 16'h01);
      wr_reg(1, 3, 16'h9);
      wr_reg(0, 3, 16'h3);
      rd_reg(0, 3, v); chk("t5_cmd", 32'(v), 32'h3);
      hlda_en = 1'b1; dreq = 4'b0110;
      run(60, 3);
      chk("t5_nxfer", n_xfer, 3);
      chk("t5_d0", 32'(xd[0]), 32'b0010);
`ifdef DMA_ROTATE_PRIO_EN
      chk("t5_d1", 32'(xd[1]), 32'b0100);
      chk("t5_a1", 32'(xa[1]), 32'h0200);
`else
      chk("t5_d1", 32'(xd[1]), 32'b0010);
      chk("t5_a1", 32'(xa[1]), 32'h0101);
`endif
      chk("t5_d2", 32'(xd[2]), 32'b0010);

      // reset in S3, then writes blocked while hrq is high
      do_reset();
      prog(0, 16'h3000, 16'd5, 16'h01);
      wr_reg(1, 3, 16'hE);
      wr_reg(0, 3, 16'h1);
      hlda_en = 1'b1; dreq = 4'b0001;
      run(30, 1);
      chk("t6_in_s3", {ior, memw}, 2'b11);
      reset = 1'b1;
      tick();
      chk("t6_rst_outs", {hrq, aen, dack, memr, memw, ior, iow, eop}, '0);
      reset = 1'b0; hlda_en = 1'b0; dreq = '0;
      prog(0, 16'h3000, 16'd5, 16'h01);
      wr_reg(1, 3, 16'hE);
      wr_reg(0, 3, 16'h1);
      dreq = 4'b0001;
      tick();
      tick();
      chk("t6_hrq", 32'(hrq), 32'h1);
      wr_reg(0, 0, 16'h5555);
      wr_reg(1, 3, 16'h0);
      rd_reg(0, 0, v); chk("t6_addr_kept", 32'(v), 32'h3000);
      rd_reg(1, 3, v); chk("t6_mask_kept", 32'(v), 32'hE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
